// File: rtl/edge_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
//   Shared types and default geometry for the edge-detection pipeline.
//   - wsc_state_t     : window_scan_ctrl sequencer states
//   - DEF_IMG_WIDTH   : default pixels per row
//   - DEF_IMG_HEIGHT  : default rows per frame
//   - pixel_t         : 8-bit greyscale pixel
// -----------------------------------------------------------------------------
package edge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN,
      DRAIN
   } wsc_state_t;

   localparam int unsigned DEF_IMG_WIDTH  = 640;
   localparam int unsigned DEF_IMG_HEIGHT = 480;

   typedef logic [7:0] pixel_t;

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
//   Column/row position of the next pixel in a raster-ordered frame.
//   Column wraps IMG_WIDTH-1 -> 0 and advances the row; the row wraps
//   IMG_HEIGHT-1 -> 0 so the counter rests at (0,0) after a full frame.
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   clear_i     synchronous clear to (0,0)
//   en_i        advance by one pixel
//   col_o       current column
//   row_o       current row
//   last_col_o  current column is IMG_WIDTH-1
//   last_pix_o  current position is the final pixel of the frame
// -----------------------------------------------------------------------------
module raster_counter
   import edge_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int unsigned COL_W      = $clog2(IMG_WIDTH),
   parameter int unsigned ROW_W      = $clog2(IMG_HEIGHT)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             en_i,
   output logic [COL_W-1:0] col_o,
   output logic [ROW_W-1:0] row_o,
   output logic             last_col_o,
   output logic             last_pix_o
);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             last_row;

   assign last_col_o = (col_q == COL_W'(IMG_WIDTH - 1));
   assign last_row   = (row_q == ROW_W'(IMG_HEIGHT - 1));
   assign last_pix_o = last_col_o & last_row;

   always_comb begin
      col_d = col_q + COL_W'(1);
      row_d = row_q;
      if (last_col_o) begin
         col_d = '0;
         row_d = last_row ? '0 : row_q + ROW_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         col_q <= '0;
         row_q <= '0;
      end else if (en_i) begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o = col_q;
   assign row_o = row_q;

endmodule

// File: rtl/window_scan_ctrl.sv
// -----------------------------------------------------------------------------
// window_scan_ctrl
//   Frame-scan sequencer for the 3x3 sliding-window datapath. Accepts a raster
//   pixel stream, drives the window shift register and the two-row line
//   buffers, and flags every cycle in which the window holds a full 3x3
//   neighbourhood together with its centre-pixel coordinates.
//
// Ports
//   clock        clock, rising edge
//   reset        synchronous active-high reset (aborts a frame, no frame_done)
//   start        begin a frame; ignored unless idle
//   pixel_valid  upstream pixel present
//   pixel_ready  pixel accepted this cycle when valid
//   shift_en     shift register / line-buffer advance (= valid & ready)
//   lb_addr      line-buffer address: column of the pixel being accepted
//   lb_wr_en     line-buffer write strobe (= shift_en)
//   win_valid    window holds a complete neighbourhood
//   win_ready    downstream consumes the window
//   win_row      centre-pixel row of the window
//   win_col      centre-pixel column of the window
//   busy         frame in progress
//   frame_done   one-cycle pulse after the last window of a frame is consumed
//   stall_cnt    (WSC_PERF_CNT_EN only) busy cycles with valid & !ready
//
// Build option
//   WSC_PERF_CNT_EN  adds the saturating stall_cnt output.
// -----------------------------------------------------------------------------
module window_scan_ctrl
   import edge_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
   // Derived widths; leave at their defaults.
   parameter int unsigned COL_W      = $clog2(IMG_WIDTH),
   parameter int unsigned ROW_W      = $clog2(IMG_HEIGHT)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             pixel_valid,
   output logic             pixel_ready,
   output logic             shift_en,
   output logic [COL_W-1:0] lb_addr,
   output logic             lb_wr_en,
   output logic             win_valid,
   input  logic             win_ready,
   output logic [ROW_W-1:0] win_row,
   output logic [COL_W-1:0] win_col,
   output logic             busy,
   output logic             frame_done
`ifdef WSC_PERF_CNT_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);

   wsc_state_t       state_q, state_d;
   logic             win_valid_q, win_valid_d;
   logic [ROW_W-1:0] win_row_q, win_row_d;
   logic [COL_W-1:0] win_col_q, win_col_d;
   logic             frame_done_q, frame_done_d;

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             last_col;
   logic             last_pix;
   logic             start_acc;
   logic             win_take;

   assign start_acc = start && (state_q == IDLE);
   assign win_take  = win_valid_q & win_ready;

   // A held window blocks new pixels so the shift register never overwrites
   // it; when it is consumed in the same cycle the next pixel may enter.
   assign busy        = (state_q != IDLE);
   assign pixel_ready = busy && (state_q != DRAIN) && !(win_valid_q && !win_ready);
   assign shift_en    = pixel_valid & pixel_ready;
   assign lb_wr_en    = shift_en;
   assign lb_addr     = col;

   raster_counter #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT),
      .COL_W      (COL_W),
      .ROW_W      (ROW_W)
   ) u_raster (
      .clk_i      (clock),
      .rst_i      (reset),
      .clear_i    (start_acc),
      .en_i       (shift_en),
      .col_o      (col),
      .row_o      (row),
      .last_col_o (last_col),
      .last_pix_o (last_pix)
   );

   always_comb begin
      state_d      = state_q;
      frame_done_d = 1'b0;
      unique case (state_q)
         IDLE:  if (start) state_d = PRIME;
         PRIME: if (shift_en && last_col && (row == ROW_W'(1))) state_d = RUN;
         RUN:   if (shift_en && last_pix) state_d = DRAIN;
         DRAIN: begin
            if (!win_valid_q || win_ready) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // In RUN every shifted pixel is in row >= 2, so only the column decides
   // whether the window is complete (columns 0-1 refill the left border).
   always_comb begin
      win_valid_d = win_valid_q;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      if (win_take) win_valid_d = 1'b0;
      if (shift_en && (state_q == RUN) && (col >= COL_W'(2))) begin
         win_valid_d = 1'b1;
         win_row_d   = row - ROW_W'(1);
         win_col_d   = col - COL_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         win_valid_q  <= 1'b0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_valid_q  <= win_valid_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign win_valid  = win_valid_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign frame_done = frame_done_q;

`ifdef WSC_PERF_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clock) begin
      if (reset || start_acc) begin
         stall_cnt_q <= '0;
      end else if (busy && pixel_valid && !pixel_ready && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_window_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_window_scan_ctrl
//   Self-checking bench for window_scan_ctrl at an 8x4 frame. A raster model
//   of accepted pixels predicts each window and queues it; windows are popped
//   and compared as the DUT presents them. Also checks handshake outputs each
//   cycle, a start-up vector table, backpressure hold, border skipping,
//   abort by reset and a start pulse while busy.
// -----------------------------------------------------------------------------
module tb_window_scan_ctrl;

   localparam int unsigned W    = 8;
   localparam int unsigned H    = 4;
   localparam int unsigned CW   = $clog2(W);
   localparam int unsigned RW   = $clog2(H);
   localparam int unsigned NPIX = W * H;
   localparam int unsigned NWIN = (W - 2) * (H - 2);

   logic          clock = 1'b0;
   logic          reset, start, pixel_valid, win_ready;
   logic          pixel_ready, shift_en, lb_wr_en, win_valid, busy, frame_done;
   logic [CW-1:0] lb_addr, win_col;
   logic [RW-1:0] win_row;
`ifdef WSC_PERF_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   always #5 clock = ~clock;

   window_scan_ctrl #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready),
      .shift_en    (shift_en),
      .lb_addr     (lb_addr),
      .lb_wr_en    (lb_wr_en),
      .win_valid   (win_valid),
      .win_ready   (win_ready),
      .win_row     (win_row),
      .win_col     (win_col),
      .busy        (busy),
      .frame_done  (frame_done)
`ifdef WSC_PERF_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   typedef struct {
      int unsigned r;
      int unsigned c;
   } win_t;

   win_t        q[$];
   bit          m_busy = 1'b0, m_fd_pend = 1'b0, m_wv = 1'b0;
   int unsigned m_col = 0, m_row = 0, m_nsh = 0;
   int unsigned f_wins = 0, f_fd = 0;

   typedef struct {
      logic        rst, st, pv, wr;
      logic        e_busy, e_pr, e_se;
      int unsigned e_addr;
      logic        e_wv, e_fd;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle checks and model update; called #1 after a negedge, ends at the
   // next negedge.
   task automatic mon_clk();
      bit   consumed, produce, exp_pr, busy_before;
      win_t w;
      consumed    = 1'b0;
      produce     = 1'b0;
      busy_before = m_busy;
      exp_pr      = m_busy && (m_nsh < NPIX) && !(m_wv && !win_ready);

      chk("busy", 32'(busy), 32'(m_busy));
      chk("frame_done", 32'(frame_done), 32'(m_fd_pend));
      chk("win_valid", 32'(win_valid), 32'(m_wv));
      chk("pixel_ready", 32'(pixel_ready), 32'(exp_pr));
      chk("shift_en", 32'(shift_en), 32'(pixel_valid && exp_pr));
      chk("lb_wr_en", 32'(lb_wr_en), 32'(pixel_valid && exp_pr));

      if (frame_done === 1'b1) f_fd++;

      if (win_valid === 1'b1 && win_ready === 1'b1) begin
         consumed = 1'b1;
         f_wins++;
         chk("win_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            w = q.pop_front();
            chk("win_row", 32'(win_row), w.r);
            chk("win_col", 32'(win_col), w.c);
         end
      end

      if (shift_en === 1'b1) begin
         chk("lb_addr", 32'(lb_addr), m_col);
         if (m_row >= 2 && m_col >= 2) begin
            produce = 1'b1;
            q.push_back('{m_row - 1, m_col - 1});
         end
         if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
         m_nsh++;
      end

      m_fd_pend = m_busy && consumed && (m_nsh == NPIX) && (q.size() == 0);
      if (m_fd_pend) m_busy = 1'b0;
      m_wv = produce ? 1'b1 : (consumed ? 1'b0 : m_wv);

      if (reset === 1'b1) begin
         m_busy = 1'b0; m_fd_pend = 1'b0; m_wv = 1'b0;
         m_col = 0; m_row = 0; m_nsh = 0;
         q.delete();
      end else if (start === 1'b1 && !busy_before) begin
         m_busy = 1'b1;
         m_col = 0; m_row = 0; m_nsh = 0;
         q.delete();
      end
      @(negedge clock);
   endtask

   task automatic step();
      #1;
      mon_clk();
   endtask

   // toggle: pixel_valid 1010; stall_n: cycles of win_ready=0 starting at
   // window (1,3); mid_start: cycle index at which start is pulsed mid-frame.
   task automatic run_frame(input bit toggle, input int unsigned stall_n,
                            input int unsigned mid_start);
      int unsigned stall_left;
      stall_left  = stall_n;
      f_wins      = 0;
      f_fd        = 0;
      start       = 1'b1;
      pixel_valid = 1'b0;
      win_ready   = 1'b1;
      step();
      start = 1'b0;
      for (int unsigned cyc = 0; cyc < 500; cyc++) begin
         pixel_valid = (m_nsh < NPIX) && (!toggle || (cyc % 2 == 0));
         win_ready   = !(f_wins == 2 && stall_left > 0);
         start       = (cyc == mid_start);
         #1;
         if (!win_ready) begin
            chk("hold_win_valid", 32'(win_valid), 32'd1);
            chk("hold_win_row", 32'(win_row), 32'd1);
            chk("hold_win_col", 32'(win_col), 32'd3);
            chk("hold_shift_en", 32'(shift_en), 32'd0);
            stall_left--;
         end
         mon_clk();
         if (f_fd != 0) break;
      end
      start       = 1'b0;
      pixel_valid = 1'b0;
      win_ready   = 1'b1;
      step();
      step();
      chk("frame_shifts", m_nsh, NPIX);
      chk("frame_windows", f_wins, NWIN);
      chk("frame_done_pulses", f_fd, 32'd1);
      chk("queue_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      // rst st pv wr | busy pr se addr wv fd
      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 1'b0};

      reset       = 1'b1;
      start       = 1'b0;
      pixel_valid = 1'b0;
      win_ready   = 1'b1;
      @(negedge clock);
      @(negedge clock);

      // Start-up table: reset beats start, start while busy ignored.
      for (int i = 0; i < 8; i++) begin
         reset       = tbl[i].rst;
         start       = tbl[i].st;
         pixel_valid = tbl[i].pv;
         win_ready   = tbl[i].wr;
         #1;
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_pixel_ready", i), 32'(pixel_ready), 32'(tbl[i].e_pr));
         chk($sformatf("tbl%0d_shift_en", i), 32'(shift_en), 32'(tbl[i].e_se));
         chk($sformatf("tbl%0d_lb_addr", i), 32'(lb_addr), tbl[i].e_addr);
         chk($sformatf("tbl%0d_win_valid", i), 32'(win_valid), 32'(tbl[i].e_wv));
         chk($sformatf("tbl%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].e_fd));
         mon_clk();
      end
      start       = 1'b0;
      pixel_valid = 1'b0;
      reset       = 1'b1;
      step();
      reset = 1'b0;
      step();

      // Full frame, steady stream.
      run_frame(1'b0, 0, 9999);
`ifdef WSC_PERF_CNT_EN
      chk("stall_cnt_free_run", stall_cnt, 32'd0);
`endif

      // Backpressure on window (1,3) for 5 cycles.
      run_frame(1'b0, 5, 9999);
`ifdef WSC_PERF_CNT_EN
      chk("stall_cnt_backpressure", stall_cnt, 32'd5);
`endif

      // pixel_valid 1010.
      run_frame(1'b1, 0, 9999);

      // start pulsed mid-frame.
      run_frame(1'b0, 0, 10);

      // Abort after pixel (2,4).
      f_fd        = 0;
      start       = 1'b1;
      pixel_valid = 1'b0;
      step();
      start       = 1'b0;
      pixel_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (m_nsh >= 2 * W + 5) break;
         step();
      end
      chk("abort_point_shifts", m_nsh, 2 * W + 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("abort_win_row", 32'(win_row), 32'd0);
      chk("abort_win_col", 32'(win_col), 32'd0);
      chk("abort_lb_addr", 32'(lb_addr), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_win_valid", 32'(win_valid), 32'd0);
      mon_clk();
      pixel_valid = 1'b0;
      repeat (4) step();
      chk("abort_no_frame_done", f_fd, 32'd0);

      // Fresh frame after the abort.
      run_frame(1'b0, 0, 9999);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
